serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/fa_cell.sv | 18 +
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p1, g1, g2;

  assign p1 = a ^ b;
  assign g1 = a & b;
  assign s  = p1 ^ cin;
  assign g2 = p1 & cin;
  assign co = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add (and, with SERIAL_ADD_SUB_EN defined, subtract) controller using a single
// full-adder cell; one result bit per RUN cycle, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q;
  logic             accept, last;
  logic             fa_s, fa_co;
  logic             sub_in, sub_q;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= sub;
    end
  end
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  // start is only honoured outside RUN, so in-flight operands stay intact.
  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt_q == LastCnt);

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0] ^ sub_q),
    .cin(carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sum_q   <= '0;
        cnt_q   <= '0;
        // Subtraction is A + ~B + 1, so the carry seeds with 1.
        carry_q <= sub_in;
        cout_q  <= 1'b0;
      end else if (state_q == RUN) begin
        a_q     <= {1'b0, a_q[WIDTH-1:1]};
        b_q     <= {1'b0, b_q[WIDTH-1:1]};
        sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
        cnt_q   <= cnt_q + CntW'(1);
        carry_q <= fa_co;
        if (last) cout_q <= fa_co;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8); sub tests enabled with SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       sub_in = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub_in),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: remaining busy cycles plus the arithmetic result.
  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_sum = 8'h00, m_res = 8'h00;
  bit         m_cout = 1'b0, m_cres = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = 8'h00;
      m_cout = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_sum  = m_res;
        m_cout = m_cres;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        bit       s_eff;
        bit [8:0] wide;
`ifdef SERIAL_ADD_SUB_EN
        s_eff = sub_in;
`else
        s_eff = 1'b0;
`endif
        m_left = 8;
        m_sum  = 8'h00;
        m_cout = 1'b0;
        if (s_eff) begin
          m_res  = a - b;
          m_cres = (a >= b);
        end else begin
          wide   = {1'b0, a} + {1'b0, b};
          m_res  = wide[7:0];
          m_cres = wide[8];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
    chk("done", {63'd0, done}, {63'd0, m_done});
    if (m_left == 0) begin
      chk("sum", {56'd0, sum}, {56'd0, m_sum});
      chk("cout", {63'd0, cout}, {63'd0, m_cout});
    end
  end

  // Drive one operation; returns with the bench sitting in the done cycle.
  task automatic op(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                    input logic [7:0] exp_sum, input logic exp_cout);
    int k;
    a = oa;
    b = ob;
    sub_in = os;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~oa;
    b = ~ob;
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 9);
    chk("lit_sum", {56'd0, sum}, {56'd0, exp_sum});
    chk("lit_cout", {63'd0, cout}, {63'd0, exp_cout});
    chk("model_sum", {56'd0, m_sum}, {56'd0, exp_sum});
    chk("model_cout", {63'd0, m_cout}, {63'd0, exp_cout});
    @(negedge clk);
    chk("done_single", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int  k;
    bit  saw_done;
    repeat (3) @(negedge clk);
    chk("rst_sum", {56'd0, sum}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_auto_start", {63'd0, busy}, 64'd0);

    op(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
    op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_SUB_EN
    op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0);
    op(8'h20, 8'h10, 1'b1, 8'h10, 1'b1);
    sub_in = 1'b0;
`endif

    // start pulsed mid-RUN with other operands must be ignored.
    a = 8'h3C;
    b = 8'h45;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 5;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ign_latency", k, 9);
    chk("ign_sum", {56'd0, sum}, 64'h81);
    @(negedge clk);
    chk("ign_single", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);

    // start held high: back-to-back operations through DONE.
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    @(negedge clk);
    a = 8'h03;
    b = 8'h04;
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat1", k, 9);
    chk("b2b_sum1", {56'd0, sum}, 64'h03);
    chk("b2b_busy_gap", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("b2b_rebusy", {63'd0, busy}, 64'd1);
    chk("b2b_done_fall", {63'd0, done}, 64'd0);
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("b2b_period", k, 9);
    chk("b2b_sum2", {56'd0, sum}, 64'h07);
    repeat (2) @(negedge clk);

    // Reset mid-RUN aborts without a done pulse.
    a = 8'h3C;
    b = 8'h45;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", {56'd0, sum}, 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {63'd0, saw_done}, 64'd0);
    op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
